// File: rtl/frame_pkg.sv
// Shared framing definitions for the UART frame serializer and the receive-side deframer.
package frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA,
    CSUM
  } frame_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Two's complement, so payload bytes plus checksum byte sum to zero mod 256.
  function automatic logic [7:0] checksum_byte(input logic [7:0] sum);
    return ~sum + 8'd1;
  endfunction

endpackage

// File: rtl/frame_byte_mux.sv
// Picks the next outgoing payload byte from the shift register and
// produces the register value with that byte consumed.
module frame_byte_mux #(
  parameter int WORD_BYTES = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic [8*WORD_BYTES-1:0] shift_reg,
  output logic [7:0]              byte_out,
  output logic [8*WORD_BYTES-1:0] shift_next
);
  localparam int W = 8 * WORD_BYTES;

  if (MSB_FIRST) begin : g_msb
    assign byte_out = shift_reg[W-1 -: 8];
    if (WORD_BYTES > 1) begin : g_shift
      assign shift_next = {shift_reg[W-9:0], 8'h00};
    end else begin : g_noshift
      assign shift_next = '0;
    end
  end else begin : g_lsb
    assign byte_out = shift_reg[7:0];
    if (WORD_BYTES > 1) begin : g_shift
      assign shift_next = {8'h00, shift_reg[W-1:8]};
    end else begin : g_noshift
      assign shift_next = '0;
    end
  end

endmodule

// File: rtl/frame_tx_serializer.sv
// Frames each accepted payload word as sync byte, payload bytes and optional
// checksum, writing every byte to all UART TX FIFOs in lockstep.
module frame_tx_serializer
  import frame_pkg::*;
#(
  parameter int         WORD_BYTES = 4,
  parameter int         NUM_CH     = 2,
  parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE,
  parameter bit         CSUM_EN    = 1'b1,
  parameter bit         MSB_FIRST  = 1'b1
) (
  input  logic                    pclk,
  input  logic                    rst_n,
  input  logic [8*WORD_BYTES-1:0] word_in,
  input  logic                    word_valid,
  output logic                    word_ready,
  input  logic [NUM_CH-1:0]       tx_full,
  output logic [NUM_CH-1:0]       wr_uart,
  output logic [7:0]              data_8,
  output logic                    busy,
  output logic [7:0]              frame_cnt
);
  localparam int W     = 8 * WORD_BYTES;
  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  frame_state_t     state, state_next;
  logic [W-1:0]     shift_reg, shift_next;
  logic [IDX_W-1:0] byte_idx;
  logic [7:0]       csum;
  logic [7:0]       cur_byte;
  logic [7:0]       emit_byte;
  logic             can_emit;
  logic             emit;
  logic             frame_done;

  frame_byte_mux #(
    .WORD_BYTES(WORD_BYTES),
    .MSB_FIRST (MSB_FIRST)
  ) u_byte_mux (
    .shift_reg (shift_reg),
    .byte_out  (cur_byte),
    .shift_next(shift_next)
  );

  assign word_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  // A byte goes out only when every channel has room; otherwise the state holds.
  assign can_emit = ~|tx_full;

  always_comb begin
    state_next = state;
    emit       = 1'b0;
    emit_byte  = SYNC_BYTE;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (word_valid) state_next = SYNC;
      end
      SYNC: begin
        if (can_emit) begin
          emit       = 1'b1;
          emit_byte  = SYNC_BYTE;
          state_next = DATA;
        end
      end
      DATA: begin
        if (can_emit) begin
          emit      = 1'b1;
          emit_byte = cur_byte;
          if (byte_idx == LAST_IDX) begin
            state_next = CSUM_EN ? CSUM : IDLE;
            frame_done = ~CSUM_EN;
          end
        end
      end
      CSUM: begin
        if (can_emit) begin
          emit       = 1'b1;
          emit_byte  = checksum_byte(csum);
          state_next = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Strobes and data are registered, so an async reset drops wr_uart at once.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      byte_idx  <= '0;
      csum      <= '0;
      wr_uart   <= '0;
      data_8    <= '0;
      frame_cnt <= '0;
    end else begin
      wr_uart <= {NUM_CH{emit}};
      if (emit) data_8 <= emit_byte;
      if (frame_done) frame_cnt <= frame_cnt + 8'd1;
      if (state == IDLE && word_valid) begin
        shift_reg <= word_in;
        csum      <= '0;
        byte_idx  <= '0;
      end else if (state == DATA && emit) begin
        shift_reg <= shift_next;
        csum      <= csum + cur_byte;
        byte_idx  <= byte_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_frame_tx_serializer.sv
// Directed bench: three serializer builds (default, LSB-first without checksum,
// single-byte single-channel) driven in parallel from one stimulus sequence.
module tb_frame_tx_serializer;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic [31:0] word_in_ab;
  logic [7:0]  word_in_c;
  logic        word_valid;
  logic [1:0]  tx_full_ab;
  logic [0:0]  tx_full_c;

  logic        word_ready_a, word_ready_b, word_ready_c;
  logic        busy_a, busy_b, busy_c;
  logic [1:0]  wr_uart_a, wr_uart_b;
  logic [0:0]  wr_uart_c;
  logic [7:0]  data_8_a, data_8_b, data_8_c;
  logic [7:0]  frame_cnt_a, frame_cnt_b, frame_cnt_c;

  int checks   = 0;
  int failures = 0;

  logic [7:0] got_a[$];
  logic [7:0] got_b[$];
  logic [7:0] got_c[$];
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] exp_c[$];
  int         first_k, last_k, partial;
  logic [7:0] exp_cnt_a, exp_cnt_b, exp_cnt_c;

  always #5 pclk = ~pclk;

  frame_tx_serializer u_dut_a (
    .pclk(pclk), .rst_n(rst_n), .word_in(word_in_ab), .word_valid(word_valid),
    .word_ready(word_ready_a), .tx_full(tx_full_ab), .wr_uart(wr_uart_a),
    .data_8(data_8_a), .busy(busy_a), .frame_cnt(frame_cnt_a)
  );

  frame_tx_serializer #(
    .WORD_BYTES(4), .NUM_CH(2), .SYNC_BYTE(8'hA5), .CSUM_EN(1'b0), .MSB_FIRST(1'b0)
  ) u_dut_b (
    .pclk(pclk), .rst_n(rst_n), .word_in(word_in_ab), .word_valid(word_valid),
    .word_ready(word_ready_b), .tx_full(tx_full_ab), .wr_uart(wr_uart_b),
    .data_8(data_8_b), .busy(busy_b), .frame_cnt(frame_cnt_b)
  );

  frame_tx_serializer #(
    .WORD_BYTES(1), .NUM_CH(1), .SYNC_BYTE(8'hA5), .CSUM_EN(1'b1), .MSB_FIRST(1'b1)
  ) u_dut_c (
    .pclk(pclk), .rst_n(rst_n), .word_in(word_in_c), .word_valid(word_valid),
    .word_ready(word_ready_c), .tx_full(tx_full_c), .wr_uart(wr_uart_c),
    .data_8(data_8_c), .busy(busy_c), .frame_cnt(frame_cnt_c)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBytes(input string tag, input logic [7:0] got[$],
                            input logic [7:0] expv[$]);
    checkOutput({tag, ".count"}, 32'(got.size()), 32'(expv.size()));
    for (int i = 0; i < expv.size() && i < got.size(); i++)
      checkOutput($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(expv[i]));
  endtask

  // Offers a word for 'hold' edges, swaps word_in at k=3, stalls with one
  // channel full for cycles [stall_at, stall_at+stall_len), captures all strobes.
  task automatic applyStimulus(input logic [31:0] word_first, input logic [31:0] word_later,
                               input logic [7:0] byte_c, input int hold,
                               input int stall_at, input int stall_len, input int run_len);
    logic in_stall;
    got_a.delete();
    got_b.delete();
    got_c.delete();
    first_k    = 0;
    last_k     = 0;
    partial    = 0;
    word_in_ab = word_first;
    word_in_c  = byte_c;
    word_valid = 1'b1;
    tx_full_ab = 2'b00;
    tx_full_c  = 1'b0;
    for (int k = 1; k <= run_len; k++) begin
      @(negedge pclk);
      if (wr_uart_a != 2'b00) begin
        got_a.push_back(data_8_a);
        if (first_k == 0) first_k = k;
        last_k = k;
        if (wr_uart_a != 2'b11) partial++;
      end
      if (wr_uart_b != 2'b00) begin
        got_b.push_back(data_8_b);
        if (wr_uart_b != 2'b11) partial++;
      end
      if (wr_uart_c != 1'b0) got_c.push_back(data_8_c);
      if (k == hold) word_valid = 1'b0;
      if (k == 3) begin
        word_in_ab = word_later;
        word_in_c  = ~byte_c;
      end
      in_stall   = (k >= stall_at) && (k < stall_at + stall_len);
      tx_full_ab = in_stall ? 2'b01 : 2'b00;
      tx_full_c  = in_stall ? 1'b1 : 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    word_in_ab = '0;
    word_in_c  = '0;
    word_valid = 1'b0;
    tx_full_ab = 2'b00;
    tx_full_c  = 1'b0;
    exp_cnt_a  = 8'd0;
    exp_cnt_b  = 8'd0;
    exp_cnt_c  = 8'd0;

    // Reset state
    repeat (2) @(negedge pclk);
    checkOutput("rst.word_ready_a", 32'(word_ready_a), 32'd1);
    checkOutput("rst.busy_a", 32'(busy_a), 32'd0);
    checkOutput("rst.wr_uart_a", 32'(wr_uart_a), 32'd0);
    checkOutput("rst.data_8_a", 32'(data_8_a), 32'h00);
    checkOutput("rst.frame_cnt_a", 32'(frame_cnt_a), 32'd0);
    checkOutput("rst.ready_busy_bc", 32'({word_ready_b, busy_b, word_ready_c, busy_c}), 32'b1010);
    rst_n = 1'b1;
    @(negedge pclk);

    // Unstalled frame on all three builds
    $display("[TB] unstalled frame");
    applyStimulus(32'h01_00_12_34, 32'hFFFF_FFFF, 8'hFF, 1, 0, 0, 10);
    exp_a = '{8'hA5, 8'h01, 8'h00, 8'h12, 8'h34, 8'hB9};
    exp_b = '{8'hA5, 8'h34, 8'h12, 8'h00, 8'h01};
    exp_c = '{8'hA5, 8'hFF, 8'h01};
    checkBytes("f1.a", got_a, exp_a);
    checkBytes("f1.b", got_b, exp_b);
    checkBytes("f1.c", got_c, exp_c);
    checkOutput("f1.first_k", 32'(first_k), 32'd2);
    checkOutput("f1.last_k", 32'(last_k), 32'd7);
    checkOutput("f1.partial", 32'(partial), 32'd0);
    exp_cnt_a++; exp_cnt_b++; exp_cnt_c++;
    checkOutput("f1.frame_cnt_a", 32'(frame_cnt_a), 32'(exp_cnt_a));
    checkOutput("f1.frame_cnt_b", 32'(frame_cnt_b), 32'(exp_cnt_b));
    checkOutput("f1.frame_cnt_c", 32'(frame_cnt_c), 32'(exp_cnt_c));
    checkOutput("f1.idle_a", 32'({word_ready_a, busy_a}), 32'b10);

    // One channel full for three cycles during the second payload byte
    $display("[TB] stalled frame");
    applyStimulus(32'h01_00_12_34, 32'hFFFF_FFFF, 8'hFF, 1, 3, 3, 14);
    checkBytes("f2.a", got_a, exp_a);
    checkBytes("f2.b", got_b, exp_b);
    checkBytes("f2.c", got_c, exp_c);
    checkOutput("f2.first_k", 32'(first_k), 32'd2);
    checkOutput("f2.last_k", 32'(last_k), 32'd10);
    checkOutput("f2.stall_gaps", 32'(last_k - first_k + 1 - got_a.size()), 32'd3);
    checkOutput("f2.partial", 32'(partial), 32'd0);
    exp_cnt_a++; exp_cnt_b++; exp_cnt_c++;
    checkOutput("f2.frame_cnt_a", 32'(frame_cnt_a), 32'(exp_cnt_a));

    // word_valid held high: back-to-back frames with one IDLE cycle between
    $display("[TB] back-to-back frames");
    applyStimulus(32'hDE_AD_BE_EF, 32'h01_00_12_34, 8'h5A, 14, 0, 0, 20);
    exp_a = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hC8,
              8'hA5, 8'h01, 8'h00, 8'h12, 8'h34, 8'hB9};
    checkBytes("b2b.a", got_a, exp_a);
    checkOutput("b2b.first_k", 32'(first_k), 32'd2);
    checkOutput("b2b.last_k", 32'(last_k), 32'd14);
    checkOutput("b2b.idle_gaps", 32'(last_k - first_k + 1 - got_a.size()), 32'd1);
    checkOutput("b2b.b_count", 32'(got_b.size()), 32'd15);
    checkOutput("b2b.c_count", 32'(got_c.size()), 32'd12);
    exp_cnt_a += 8'd2; exp_cnt_b += 8'd3; exp_cnt_c += 8'd4;
    checkOutput("b2b.frame_cnt_a", 32'(frame_cnt_a), 32'(exp_cnt_a));
    checkOutput("b2b.frame_cnt_b", 32'(frame_cnt_b), 32'(exp_cnt_b));
    checkOutput("b2b.frame_cnt_c", 32'(frame_cnt_c), 32'(exp_cnt_c));

    // Reset pulsed while in DATA
    $display("[TB] reset mid-frame");
    word_in_ab = 32'h01_00_12_34;
    word_valid = 1'b1;
    @(negedge pclk);
    word_valid = 1'b0;
    repeat (2) @(negedge pclk);
    checkOutput("mid.pre_wr_uart_a", 32'(wr_uart_a), 32'h3);
    checkOutput("mid.pre_busy_a", 32'(busy_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid.wr_uart_a", 32'(wr_uart_a), 32'd0);
    checkOutput("mid.frame_cnt_a", 32'(frame_cnt_a), 32'd0);
    checkOutput("mid.data_8_a", 32'(data_8_a), 32'h00);
    checkOutput("mid.ready_busy_a", 32'({word_ready_a, busy_a}), 32'b10);
    checkOutput("mid.frame_cnt_b", 32'(frame_cnt_b), 32'd0);
    @(negedge pclk);
    rst_n     = 1'b1;
    exp_cnt_a = 8'd0;
    exp_cnt_b = 8'd0;
    exp_cnt_c = 8'd0;

    applyStimulus(32'h01_00_12_34, 32'hFFFF_FFFF, 8'hFF, 1, 0, 0, 10);
    exp_a = '{8'hA5, 8'h01, 8'h00, 8'h12, 8'h34, 8'hB9};
    checkBytes("post.a", got_a, exp_a);
    exp_cnt_a++; exp_cnt_b++; exp_cnt_c++;
    checkOutput("post.frame_cnt_a", 32'(frame_cnt_a), 32'(exp_cnt_a));

    // frame_cnt wraps after 256 frames
    $display("[TB] frame counter wrap");
    for (int f = 2; f <= 255; f++) begin
      applyStimulus(32'h01_00_12_34, 32'hFFFF_FFFF, 8'hFF, 1, 0, 0, 8);
      exp_cnt_a++; exp_cnt_b++; exp_cnt_c++;
    end
    checkOutput("wrap.cnt255_a", 32'(frame_cnt_a), 32'(exp_cnt_a));
    checkOutput("wrap.cnt255_c", 32'(frame_cnt_c), 32'(exp_cnt_c));
    applyStimulus(32'h01_00_12_34, 32'hFFFF_FFFF, 8'hFF, 1, 0, 0, 8);
    exp_cnt_a++; exp_cnt_b++; exp_cnt_c++;
    checkOutput("wrap.cnt0_a", 32'(frame_cnt_a), 32'(exp_cnt_a));
    checkOutput("wrap.cnt0_b", 32'(frame_cnt_b), 32'(exp_cnt_b));
    checkOutput("wrap.cnt0_c", 32'(frame_cnt_c), 32'(exp_cnt_c));
    checkBytes("wrap.c", got_c, exp_c);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
